// File: rtl/arm_multicycle_ctrl.sv
// Multicycle main controller for an ARM subset (ADD/SUB/AND/ORR, LDR/STR, B).
// Sequences a shared ALU/memory datapath, owns the NZCV register and the
// condition check, and bounds every memory handshake with a wait counter.
// Control outputs are registered from the next state so they line up with
// the state they belong to. Two terms need the handshake of the current
// cycle: the fetch strobes (ir_write and the fetch part of pc_write), which
// are qualified by mem_ready, and imm_src in DECODE, which follows the
// freshly latched op field.
module arm_multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] cond,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   input  logic [3:0] alu_flags,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] imm_src,
   output logic [1:0] reg_src,
   output logic [1:0] alu_control,
   output logic [3:0] flags,
   output logic       mem_err
);

   localparam int unsigned WAIT_W = 8;
   localparam int unsigned CMD_W  = 4;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned REG_W  = 4;

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   localparam logic [CMD_W-1:0] CMD_AND = CMD_W'(4'b0000);
   localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(4'b0010);
   localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(4'b0100);
   localparam logic [CMD_W-1:0] CMD_ORR = CMD_W'(4'b1100);

   localparam logic [SEL_W-1:0] ALU_ADD = SEL_W'(2'b00);
   localparam logic [SEL_W-1:0] ALU_SUB = SEL_W'(2'b01);
   localparam logic [SEL_W-1:0] ALU_ORR = SEL_W'(2'b10);
   localparam logic [SEL_W-1:0] ALU_AND = SEL_W'(2'b11);

   localparam logic [REG_W-1:0] REG_PC = REG_W'(4'hF);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        flags_q, flags_d;
   logic              cond_ex_q, cond_ex_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   logic              mem_req_q, mem_req_d;
   logic              mem_write_q, mem_write_d;
   logic              adr_src_q, adr_src_d;
   logic              pc_write_q, pc_write_d;
   logic              reg_write_q, reg_write_d;
   logic              alu_src_a_q, alu_src_a_d;
   logic [1:0]        alu_src_b_q, alu_src_b_d;
   logic [1:0]        result_src_q, result_src_d;
   logic [1:0]        imm_src_q, imm_src_d;
   logic [1:0]        reg_src_q, reg_src_d;
   logic [1:0]        alu_control_q, alu_control_d;
   logic              mem_err_q, mem_err_d;

   logic              cmd_ok;
   logic              cmd_arith;
   logic [SEL_W-1:0]  alu_sel;
   logic              mem_done;
   logic              mem_wait;
   logic              timeout;
   logic              fetch_done;

   // ARM condition field against the current NZCV; 1111 never executes
   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      logic pass;
      {n, z, cy, v} = f;
      pass = 1'b0;
      case (c)
         4'b0000: pass = z;
         4'b0001: pass = !z;
         4'b0010: pass = cy;
         4'b0011: pass = !cy;
         4'b0100: pass = n;
         4'b0101: pass = !n;
         4'b0110: pass = v;
         4'b0111: pass = !v;
         4'b1000: pass = cy && !z;
         4'b1001: pass = !cy || z;
         4'b1010: pass = (n == v);
         4'b1011: pass = (n != v);
         4'b1100: pass = !z && (n == v);
         4'b1101: pass = z || (n != v);
         4'b1110: pass = 1'b1;
         default: pass = 1'b0;
      endcase
      return pass;
   endfunction

   // Data-processing command decode; unsupported commands select ADD and flag invalid
   always_comb begin
      cmd_ok    = 1'b0;
      cmd_arith = 1'b0;
      alu_sel   = ALU_ADD;
      case (funct[4:1])
         CMD_ADD: begin cmd_ok = 1'b1; cmd_arith = 1'b1; alu_sel = ALU_ADD; end
         CMD_SUB: begin cmd_ok = 1'b1; cmd_arith = 1'b1; alu_sel = ALU_SUB; end
         CMD_AND: begin cmd_ok = 1'b1; alu_sel = ALU_AND; end
         CMD_ORR: begin cmd_ok = 1'b1; alu_sel = ALU_ORR; end
         default: ;
      endcase
   end

   // Handshake qualifiers; a request only counts once mem_req is actually driven
   assign mem_done   = mem_req_q && mem_ready;
   assign mem_wait   = mem_req_q && !mem_ready;
   assign timeout    = mem_wait && (wait_q >= WAIT_LIMIT);
   assign fetch_done = (state_q == S_FETCH) && mem_done;

   // Next state, flag/condition bookkeeping, wait counter and next-cycle outputs
   always_comb begin
      state_d       = state_q;
      flags_d       = flags_q;
      cond_ex_d     = cond_ex_q;
      wait_d        = wait_q;
      mem_err_d     = 1'b0;
      mem_req_d     = 1'b0;
      mem_write_d   = 1'b0;
      adr_src_d     = 1'b0;
      pc_write_d    = 1'b0;
      reg_write_d   = 1'b0;
      alu_src_a_d   = 1'b0;
      alu_src_b_d   = 2'b00;
      result_src_d  = 2'b00;
      imm_src_d     = 2'b00;
      reg_src_d     = 2'b00;
      alu_control_d = ALU_ADD;

      unique case (state_q)
         S_FETCH: begin
            if (mem_done) begin
               state_d = S_DECODE;
            end else if (timeout) begin
               state_d   = S_FETCH;
               mem_err_d = 1'b1;
            end
         end
         S_DECODE: begin
            cond_ex_d = cond_pass(cond, flags_q);
            unique case (op)
               2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            state_d = funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            if (mem_done) begin
               state_d = S_MEMWB;
            end else if (timeout) begin
               state_d   = S_FETCH;
               mem_err_d = 1'b1;
            end
         end
         S_MEMWR: begin
            if (mem_done) begin
               state_d = S_FETCH;
            end else if (timeout) begin
               state_d   = S_FETCH;
               mem_err_d = 1'b1;
            end
         end
         S_EXECR, S_EXECI: begin
            if (cmd_ok) begin
               state_d = S_ALUWB;
               if (funct[0] && cond_ex_q) begin
                  flags_d[3:2] = alu_flags[3:2];
                  if (cmd_arith) begin
                     flags_d[1:0] = alu_flags[1:0];
                  end
               end
            end else begin
               cond_ex_d = 1'b0;
               state_d   = S_FETCH;
            end
         end
         S_MEMWB, S_ALUWB, S_BRANCH: begin
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // Wait counter restarts on every state entry (including a timeout re-fetch)
      if ((state_d != state_q) || timeout) begin
         wait_d = '0;
      end else if (mem_wait) begin
         wait_d = wait_q + WAIT_W'(1);
      end

      // Control word for the state being entered
      unique case (state_d)
         S_FETCH: begin
            mem_req_d    = 1'b1;
            alu_src_a_d  = 1'b1;
            alu_src_b_d  = 2'b10;
            result_src_d = 2'b10;
         end
         S_DECODE: begin
            alu_src_a_d = 1'b1;
            alu_src_b_d = 2'b10;
         end
         S_MEMADR: begin
            alu_src_b_d = 2'b01;
            imm_src_d   = 2'b01;
         end
         S_MEMRD: begin
            mem_req_d = 1'b1;
            adr_src_d = 1'b1;
         end
         S_MEMWB: begin
            result_src_d = 2'b01;
            if (rd == REG_PC) begin
               pc_write_d = cond_ex_d;
            end else begin
               reg_write_d = cond_ex_d;
            end
         end
         S_MEMWR: begin
            mem_req_d   = 1'b1;
            mem_write_d = 1'b1;
            adr_src_d   = 1'b1;
            reg_src_d   = 2'b10;
         end
         S_EXECR: begin
            alu_control_d = alu_sel;
         end
         S_EXECI: begin
            alu_src_b_d   = 2'b01;
            alu_control_d = alu_sel;
         end
         S_ALUWB: begin
            reg_write_d = cond_ex_d && (rd != REG_PC);
            pc_write_d  = cond_ex_d && (rd == REG_PC);
         end
         S_BRANCH: begin
            imm_src_d    = 2'b10;
            alu_src_b_d  = 2'b01;
            result_src_d = 2'b10;
            reg_src_d    = 2'b01;
            pc_write_d   = cond_ex_d;
         end
         default: ;
      endcase
   end

   // State, flags and registered control word; reset abandons any access in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_FETCH;
         flags_q       <= '0;
         cond_ex_q     <= 1'b0;
         wait_q        <= '0;
         mem_req_q     <= 1'b0;
         mem_write_q   <= 1'b0;
         adr_src_q     <= 1'b0;
         pc_write_q    <= 1'b0;
         reg_write_q   <= 1'b0;
         alu_src_a_q   <= 1'b0;
         alu_src_b_q   <= 2'b00;
         result_src_q  <= 2'b00;
         imm_src_q     <= 2'b00;
         reg_src_q     <= 2'b00;
         alu_control_q <= 2'b00;
         mem_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         flags_q       <= flags_d;
         cond_ex_q     <= cond_ex_d;
         wait_q        <= wait_d;
         mem_req_q     <= mem_req_d;
         mem_write_q   <= mem_write_d;
         adr_src_q     <= adr_src_d;
         pc_write_q    <= pc_write_d;
         reg_write_q   <= reg_write_d;
         alu_src_a_q   <= alu_src_a_d;
         alu_src_b_q   <= alu_src_b_d;
         result_src_q  <= result_src_d;
         imm_src_q     <= imm_src_d;
         reg_src_q     <= reg_src_d;
         alu_control_q <= alu_control_d;
         mem_err_q     <= mem_err_d;
      end
   end

   // Output map; fetch strobes fire in the cycle the instruction word arrives
   assign mem_req     = mem_req_q;
   assign mem_write   = mem_write_q;
   assign adr_src     = adr_src_q;
   assign ir_write    = fetch_done;
   assign pc_write    = pc_write_q || fetch_done;
   assign reg_write   = reg_write_q;
   assign alu_src_a   = alu_src_a_q;
   assign alu_src_b   = alu_src_b_q;
   assign result_src  = result_src_q;
   assign imm_src     = (state_q == S_DECODE) ? op : imm_src_q;
   assign reg_src     = reg_src_q;
   assign alu_control = alu_control_q;
   assign flags       = flags_q;
   assign mem_err     = mem_err_q;

endmodule
